// File: rtl/shift_arb_pkg.sv
// Shared types and widths for the shift arbiter.
// Holds the FSM state enum and datapath widths.
package shift_arb_pkg;

  localparam int SH_IN_W  = 24;
  localparam int SH_OUT_W = 48;
  localparam int SHIFT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection, purely combinational.
// Ports: req (request bits), last_grant (previous winner),
//        grant (one-hot), grant_idx (winner index).
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx
);

  logic [IW-1:0] j;

  // Walk from the lowest-priority slot up to the highest;
  // the last hit written is the winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    j         = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = IW'((int'(last_grant) + k) % N_REQ);
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = j;
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one 24-to-48-bit right shifter among N_REQ requesters.
// Ports: req_* (requester side), sh_* (shifter side),
//        rsp_* (response side), clk/rst (async high reset).
// Option: SHIFT_ARB_TIMEOUT_EN adds a WAIT watchdog that
//         answers with rsp_err=1 after TIMEOUT cycles.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 16,
  localparam int IW      = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [SHIFT_W*N_REQ-1:0]   req_shift,
  input  logic [SH_IN_W*N_REQ-1:0]   req_data,
  output logic                       sh_valid_in,
  output logic [SHIFT_W-1:0]         sh_shift,
  output logic [SH_IN_W-1:0]         sh_in_data,
  input  logic                       sh_valid_out,
  input  logic [SH_OUT_W-1:0]        sh_out_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IW-1:0]              rsp_id,
  output logic [SH_OUT_W-1:0]        rsp_data,
  output logic                       rsp_err
);

  state_t               state;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        op_id;
  logic [SHIFT_W-1:0]   op_shift;
  logic [SH_IN_W-1:0]   op_data;
  logic [N_REQ-1:0]     grant;
  logic [IW-1:0]        gidx;
  logic                 hs;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (gidx)
  );

  // The arbiter only grants valid bits, so any valid in
  // IDLE is a completed handshake.
  assign hs         = (state == IDLE) && (|req_valid);
  assign req_ready  = (state == IDLE) ? grant : '0;
  assign sh_shift   = op_shift;
  assign sh_in_data = op_data;
  assign rsp_id     = op_id;

`ifdef SHIFT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign rsp_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= IW'(N_REQ - 1);
      op_id       <= '0;
      op_shift    <= '0;
      op_data     <= '0;
      sh_valid_in <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
`ifdef SHIFT_ARB_TIMEOUT_EN
      rsp_err     <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            state       <= ISSUE;
            last_grant  <= gidx;
            op_id       <= gidx;
            op_shift    <= req_shift[int'(gidx)*SHIFT_W +: SHIFT_W];
            op_data     <= req_data[int'(gidx)*SH_IN_W +: SH_IN_W];
            sh_valid_in <= 1'b1;
          end
        end
        ISSUE: begin
          state       <= WAIT;
          sh_valid_in <= 1'b0;
`ifdef SHIFT_ARB_TIMEOUT_EN
          cnt         <= '0;
`endif
        end
        WAIT: begin
          if (sh_valid_out) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= sh_out_data;
`ifdef SHIFT_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
          end else begin
            cnt       <= cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
`ifdef SHIFT_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized self-checking bench for shift_arbiter.
// Transaction-level reference model plus directed cases.
module tb_shift_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [8*N-1:0]  req_shift;
  logic [24*N-1:0] req_data;
  logic          sh_valid_in;
  logic [7:0]    sh_shift;
  logic [23:0]   sh_in_data;
  logic          sh_valid_out;
  logic [47:0]   sh_out_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [47:0]   rsp_data;
  logic          rsp_err;

  logic          vo_q;
  logic          vo_kick;
  logic          sh_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_shift    (req_shift),
    .req_data     (req_data),
    .sh_valid_in  (sh_valid_in),
    .sh_shift     (sh_shift),
    .sh_in_data   (sh_in_data),
    .sh_valid_out (sh_valid_out),
    .sh_out_data  (sh_out_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err)
  );

  // Shifter model: one-cycle latency right shift of {data, 24'b0}.
  always @(posedge clk) begin
    vo_q        <= sh_valid_in && sh_en;
    sh_out_data <= {sh_in_data, 24'h0} >> sh_shift;
  end
  assign sh_valid_out = vo_q | vo_kick;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Reference model state
  int          cyc = 0;
  bit          busy = 0;
  bit          seen = 0;
  bit          e_to = 0;
  int          last = N - 1;
  int          hs_cyc = 0;
  int          e_id = 0;
  logic [7:0]  e_shift;
  logic [23:0] e_din;
  logic [47:0] e_res;
  int          grants[$];
  int          hs_q[$];

  always @(negedge clk) begin
    int w;
    logic [N-1:0] er;
    cyc++;
    if (rst) begin
      busy = 0;
      last = N - 1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_sh_valid", sh_valid_in, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_operands", {sh_shift, sh_in_data}, 0);
    end else if (busy) begin
      check("ready_busy", req_ready, 0);
      if (cyc == hs_cyc + 1) begin
        check("issue_strobe", sh_valid_in, 1);
        check("issue_shift", sh_shift, e_shift);
        check("issue_data", sh_in_data, e_din);
      end else begin
        check("issue_once", sh_valid_in, 0);
      end
      if (rsp_valid) begin
        if (!seen) check("latency", cyc - hs_cyc, e_to ? TO + 2 : 3);
        seen = 1;
        check("rsp_id", rsp_id, e_id);
        check("rsp_data", rsp_data, e_to ? 48'h0 : e_res);
        check("rsp_err", rsp_err, e_to);
        if (rsp_ready) busy = 0;
      end
    end else begin
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_sh_valid", sh_valid_in, 0);
      er = '0;
      w = rr_pick(req_valid, last);
      if (w >= 0) er[w] = 1'b1;
      check("grant", req_ready, er);
      if (w >= 0) begin
        logic [47:0] t;
        busy    = 1;
        seen    = 0;
        hs_cyc  = cyc;
        last    = w;
        e_id    = w;
        e_shift = req_shift[8*w +: 8];
        e_din   = req_data[24*w +: 24];
        t       = {e_din, 24'h0};
        e_res   = t >> e_shift;
        e_to    = !sh_en;
        grants.push_back(w);
        hs_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      tick();
    end
    check("drain", busy, 0);
  endtask

  task automatic set_req(input int i, input logic [7:0] s,
                         input logic [23:0] d);
    req_shift[8*i +: 8]   = s;
    req_data[24*i +: 24]  = d;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_shift = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    vo_kick   = 1'b0;
    sh_en     = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // All four held valid: 0,1,2,3,0 every 4 cycles
    for (int i = 0; i < N; i++) set_req(i, 8'(i + 1), 24'(i * 24'h111111));
    grants.delete();
    hs_q.delete();
    req_valid = '1;
    repeat (18) tick();
    check("n_grants", grants.size() >= 5, 1);
    for (int i = 0; i < 5; i++) check("rr_order", grants[i], i % N);
    for (int i = 1; i < 5; i++) check("rr_period", hs_q[i] - hs_q[i-1], 4);
    idle_wait();

    // Single request from requester 2
    set_req(2, 8'd4, 24'h800000);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    check("single_seen", rsp_valid, 1);
    check("single_id", rsp_id, 2);
    check("single_data", rsp_data, 48'h080000000000);
    idle_wait();

    // Back-pressure on the response for 5 cycles
    set_req(0, 8'd8, 24'h123456);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, 48'h001234560000);
      check("hold_id", rsp_id, 0);
      check("hold_ready", req_ready, 0);
      tick();
    end
    idle_wait();

    // Oversized shift passes through, result is zero
    set_req(3, 8'd200, 24'hFFFFFF);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    check("big_shift_strobe", sh_valid_in, 1);
    check("big_shift_amt", sh_shift, 200);
    n = 0;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    check("big_shift_data", rsp_data, 0);
    idle_wait();

    // Reset pulse in WAIT, then a stale shifter strobe
    set_req(1, 8'd2, 24'hABCDEF);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vo_kick = 1'b1;
    tick();
    vo_kick = 1'b0;
    tick();
    tick();
    check("no_rsp_after_rst", rsp_valid, 0);
    grants.delete();
    req_valid = '1;
    tick();
    req_valid = '0;
    check("post_rst_grant", grants.size() > 0 ? grants[0] : -1, 0);
    idle_wait();

    // Random traffic with random response back-pressure
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom & $urandom);
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom % 8 == 0) ? 8'($urandom_range(48, 255))
                                       : 8'($urandom_range(0, 47)),
                24'($urandom));
      rsp_ready = ($urandom % 4) != 0;
      tick();
    end
    idle_wait();

`ifdef SHIFT_ARB_TIMEOUT_EN
    // Shifter never answers: watchdog response
    sh_en = 1'b0;
    set_req(2, 8'd1, 24'h000001);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    idle_wait();
    sh_en = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
